// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data path widths, opcode map and the fetch
// state encoding used by the instruction-fetch controller.
package cpu_pkg;

  localparam int ADDR_W = 4;
  localparam int INST_W = 16;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b1010;
  localparam logic [3:0] OP_SUBI = 4'b1011;
  localparam logic [3:0] OP_BR   = 4'b1100;
  localparam logic [3:0] OP_OUT  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input logic [INST_W-1:0] inst);
    return inst[INST_W-1 -: 4];
  endfunction

  function automatic logic [ADDR_W-1:0] branch_target(input logic [INST_W-1:0] inst);
    return inst[11:8];
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Next-PC selection for the fetch sequencer.
// Priority: execute redirect, then folded unconditional branch, then
// sequential increment (wraps modulo 2^ADDR_W).
module pc_next_logic
  import cpu_pkg::*;
#(
  parameter logic [3:0] BR_OPCODE = OP_BR
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [INST_W-1:0] inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc_next
);

  // choose the following fetch address
  always_comb begin
    pc_next = pc + ADDR_W'(1);
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (opcode_of(inst) == BR_OPCODE) begin
      pc_next = branch_target(inst);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller for the 16-entry program ROM.
// Optional build macro: FETCH_STEP_EN adds a 'step' input that gates every
// ROM capture (board single-stepping). Without it captures happen whenever
// the handshake allows.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | after reset, waiting for start
// ST_FETCH  | nothing held; capture rom_data at pc next edge
// ST_ISSUE  | out_inst valid; on accept capture the next one back-to-back
// ST_HALTED | stopped by halt_req, waiting for start
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [3:0]        BR_OPCODE = OP_BR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
`ifdef FETCH_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              running,
  output logic [7:0]        issue_cnt
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              accept;
  logic              step_ok;

`ifdef FETCH_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  assign rom_addr = pc;
  assign accept   = out_valid & out_ready;
  assign running  = (state == ST_FETCH) || (state == ST_ISSUE);

  pc_next_logic #(
    .BR_OPCODE(BR_OPCODE)
  ) u_pc_next (
    .pc            (pc),
    .inst          (rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc_next       (pc_next)
  );

  // fetch FSM: pc, output register, handshake and accepted-instruction count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      out_inst  <= '0;
      out_pc    <= '0;
      out_valid <= 1'b0;
      issue_cnt <= '0;
    end else begin
      // a redirect in the same cycle as an accept cancels that transfer
      if (accept && !redirect_valid) begin
        issue_cnt <= issue_cnt + 8'd1;
      end

      case (state)
        ST_IDLE, ST_HALTED: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (start) begin
            state <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (redirect_valid) begin
            pc <= pc_next;
          end else if (halt_req) begin
            state <= ST_HALTED;
          end else if (step_ok) begin
            out_inst  <= rom_data;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc_next;
            state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (redirect_valid) begin
            pc        <= pc_next;
            out_valid <= 1'b0;
            state     <= ST_FETCH;
          end else if (out_ready) begin
            if (halt_req) begin
              out_valid <= 1'b0;
              state     <= ST_HALTED;
            end else if (step_ok) begin
              out_inst <= rom_data;
              out_pc   <= pc;
              pc       <= pc_next;
            end else begin
              // accepted but no step pulse: wait in FETCH for the next one
              out_valid <= 1'b0;
              state     <= ST_FETCH;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector tables plus a
// hand-written asynchronous reset sequence.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] out_inst;
  logic [3:0]  out_pc;
  logic        out_valid;
  logic        out_ready;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic        running;
  logic [7:0]  issue_cnt;
`ifdef FETCH_STEP_EN
  logic        step;
`endif

  logic [15:0] rom [16];
  assign rom_data = rom[rom_addr];

  int total;
  int bad;

  typedef struct {
    logic       start;
    logic       ready;
    logic       halt;
    logic       rv;
    logic [3:0] rpc;
    logic       ev;
    logic [3:0] epc;
    logic [3:0] eaddr;
    logic [7:0] ecnt;
    logic       erun;
  } vec_t;

  vec_t vq[$];

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .halt_req      (halt_req),
`ifdef FETCH_STEP_EN
    .step          (step),
`endif
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .running       (running),
    .issue_cnt     (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic r, input logic h, input logic rv,
                     input logic [3:0] rpc, input logic ev, input logic [3:0] epc,
                     input logic [3:0] eaddr, input logic [7:0] ecnt, input logic erun);
    vec_t v;
    v.start = s; v.ready = r; v.halt = h; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.ecnt = ecnt; v.erun = erun;
    vq.push_back(v);
  endtask

  // vector k (k>=1) of a free-running stream started by vector 0
  task automatic add_stream(input int k);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'(k - 1), 4'(k), 8'(k - 1), 1'b1);
  endtask

  task automatic idle_inputs();
    start = 1'b0; halt_req = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 4'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic run_vectors(input string tname);
    foreach (vq[i]) begin
      start = vq[i].start; out_ready = vq[i].ready; halt_req = vq[i].halt;
      redirect_valid = vq[i].rv; redirect_pc = vq[i].rpc;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d].valid", tname, i), 16'(out_valid), 16'(vq[i].ev));
      check($sformatf("%s[%0d].out_pc", tname, i), 16'(out_pc), 16'(vq[i].epc));
      check($sformatf("%s[%0d].rom_addr", tname, i), 16'(rom_addr), 16'(vq[i].eaddr));
      check($sformatf("%s[%0d].issue_cnt", tname, i), 16'(issue_cnt), 16'(vq[i].ecnt));
      check($sformatf("%s[%0d].running", tname, i), 16'(running), 16'(vq[i].erun));
      if (vq[i].ev) check($sformatf("%s[%0d].inst", tname, i), out_inst, rom[vq[i].epc]);
    end
    vq.delete();
    idle_inputs();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
`ifdef FETCH_STEP_EN
    step = 1'b1;
`endif
    idle_inputs();
    for (int i = 0; i < 16; i++)
      rom[i] = (i % 2 == 0) ? {4'hA, 4'(i), 8'h01} : 16'hF000;

    // reset state
    do_reset();
    #1;
    check("rst.valid", 16'(out_valid), 16'd0);
    check("rst.rom_addr", 16'(rom_addr), 16'd0);
    check("rst.out_inst", out_inst, 16'd0);
    check("rst.issue_cnt", 16'(issue_cnt), 16'd0);
    check("rst.running", 16'(running), 16'd0);

    // streaming with wrap 15 -> 0 and 17 accepts
    do_reset();
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 8'd0, 1'b1);
    for (int k = 1; k <= 18; k++) add_stream(k);
    run_vectors("stream");

    // backpressure at out_pc 4
    do_reset();
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 8'd0, 1'b1);
    for (int k = 1; k <= 5; k++) add_stream(k);
    for (int k = 0; k < 5; k++)
      add(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd5, 8'd4, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd6, 8'd5, 1'b1);
    run_vectors("stall");

    // folded branch at pc 3 -> 15, no bubble
    rom[3] = 16'hCF00;
    do_reset();
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 8'd0, 1'b1);
    for (int k = 1; k <= 3; k++) add_stream(k);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 4'd15, 8'd3, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd15, 4'd0, 8'd4, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 4'd1, 8'd5, 1'b1);
    run_vectors("branch");
    rom[3] = 16'hF000;

    // redirect to 9 while out_pc 6 is being accepted
    do_reset();
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 8'd0, 1'b1);
    for (int k = 1; k <= 7; k++) add_stream(k);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 4'd6, 4'd9, 8'd6, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 4'd10, 8'd6, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd10, 4'd11, 8'd7, 1'b1);
    run_vectors("redirect");

    // halt after out_pc 7 is accepted, then restart
    do_reset();
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 8'd0, 1'b1);
    for (int k = 1; k <= 8; k++) add_stream(k);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd7, 4'd8, 8'd8, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd7, 4'd8, 8'd8, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd7, 4'd8, 8'd8, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd8, 4'd9, 8'd8, 1'b1);
    run_vectors("halt");

    // redirect while idle, halt while fetching
    do_reset();
    add(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 4'd5, 8'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5, 8'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5, 8'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5, 8'd0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 4'd6, 8'd0, 1'b1);
    run_vectors("idle_ctl");

    // asynchronous reset between edges while issuing
    do_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst.pre_valid", 16'(out_valid), 16'd1);
    check("arst.pre_out_pc", 16'(out_pc), 16'd2);
    #3 rst = 1'b1;
    #1;
    check("arst.valid", 16'(out_valid), 16'd0);
    check("arst.rom_addr", 16'(rom_addr), 16'd0);
    check("arst.running", 16'(running), 16'd0);
    check("arst.issue_cnt", 16'(issue_cnt), 16'd0);
    check("arst.out_pc", 16'(out_pc), 16'd0);
    check("arst.out_inst", out_inst, 16'd0);
    #1 rst = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("arst.idle_valid", 16'(out_valid), 16'd0);
    check("arst.idle_running", 16'(running), 16'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("arst.restart_valid", 16'(out_valid), 16'd1);
    check("arst.restart_out_pc", 16'(out_pc), 16'd0);
    check("arst.restart_inst", out_inst, rom[0]);
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
